// File: rtl/bcd_pkg.sv
// bcd_pkg: shared types, constants and sizing check for the binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int         BCD_DIGIT_W = 4;
   localparam logic [3:0] ADD3_THRESH = 4'd5;
   localparam logic [3:0] ADD3_VAL    = 4'd3;

   // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
   function automatic bit digits_ok(input int bin_w, input int digits);
      longint p = 1;
      for (int i = 0; i < digits; i++) p = p * 10;
      return p > ((longint'(1) << bin_w) - 1);
   endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// bcd_add3_digit: double-dabble correction, adds 3 to a digit field holding 5 or more.
module bcd_add3_digit
   import bcd_pkg::*;
(
   input  logic [BCD_DIGIT_W-1:0] digit,
   output logic [BCD_DIGIT_W-1:0] fixed
);

   assign fixed = (digit >= ADD3_THRESH) ? digit + ADD3_VAL : digit;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter, one bit per clock,
// with valid/ready handshakes on input and output.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [BIN_W-1:0]              bin_in,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out,
   output logic                          busy
);

   localparam int BW = BCD_DIGIT_W * DIGITS;
   localparam int RW = BW + BIN_W;
   localparam int CW = $clog2(BIN_W + 1);

   if (!digits_ok(BIN_W, DIGITS)) begin : g_size_check
      $fatal(1, "bin_to_bcd_seq: DIGITS too small for BIN_W");
   end

   state_t        state, state_nx;
   logic [RW-1:0] sr, sr_adj, sr_nx;
   logic [CW-1:0] cnt;
   logic          last;

   assign sr_adj[BIN_W-1:0] = sr[BIN_W-1:0];

   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_add3_digit u_add3 (
         .digit (sr[BIN_W+BCD_DIGIT_W*i +: BCD_DIGIT_W]),
         .fixed (sr_adj[BIN_W+BCD_DIGIT_W*i +: BCD_DIGIT_W])
      );
   end

   assign sr_nx     = sr_adj << 1;
   assign last      = (cnt == CW'(1));
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state == SHIFT);

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = in_valid ? SHIFT : IDLE;
         SHIFT:   state_nx = last ? DONE : SHIFT;
         DONE:    state_nx = out_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         sr      <= '0;
         cnt     <= '0;
         bcd_out <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && in_valid) begin
            sr  <= {{BW{1'b0}}, bin_in};
            cnt <= CW'(BIN_W);
         end else if (state == SHIFT) begin
            sr  <= sr_nx;
            cnt <= cnt - CW'(1);
            if (last) bcd_out <= sr_nx[RW-1 -: BW];
         end
      end
   end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench; driver pushes decimal-derived expectations,
// an independent monitor pops and compares on each output handshake.
module tb_bin_to_bcd_seq;

   localparam int BIN_W  = 8;
   localparam int DIGITS = 3;
   localparam int BW     = 4 * DIGITS;

   logic          clk = 0;
   logic          rst_n = 0;
   logic          in_valid = 0;
   logic          in_ready;
   logic [BIN_W-1:0] bin_in = '0;
   logic          out_valid;
   logic          out_ready = 1;
   logic [BW-1:0] bcd_out;
   logic          busy;

   int passed = 0;
   int total  = 0;
   int cyc    = 0;
   logic [BW-1:0] exp_q[$];
   int            acc_q[$];
   bit            prev_ov = 0;
   bit            rand_on = 0;

   bin_to_bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .bin_in    (bin_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bcd_out   (bcd_out),
      .busy      (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   // Decimal digits by plain division, least significant first.
   function automatic logic [BW-1:0] ref_bcd(input int v);
      logic [BW-1:0] r = '0;
      for (int d = 0; d < DIGITS; d++) begin
         r[4*d +: 4] = 4'(v % 10);
         v = v / 10;
      end
      return r;
   endfunction

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_ov = 0;
      end else begin
         if (out_valid && !prev_ov) begin
            if (acc_q.size() == 0) check("spurious_out_valid", 1, 0);
            else check("latency", cyc - acc_q.pop_front(), BIN_W + 1);
            for (int d = 0; d < DIGITS; d++)
               check("digit_range", int'(bcd_out[4*d +: 4] <= 4'd9), 1);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_result", 1, 0);
            else check("bcd_out", int'(bcd_out), int'(exp_q.pop_front()));
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_bcd(int'(bin_in)));
            acc_q.push_back(cyc);
         end
         prev_ov = out_valid;
      end
   end

   // Called just after a rising edge; returns just after the accepting edge.
   task automatic send(input int v, output int c);
      int n = 0;
      bit acc = 0;
      bin_in   = BIN_W'(v);
      in_valid = 1;
      c = 0;
      while (!acc && n < 200) begin
         @(negedge clk);
         acc = in_ready;
         c = cyc;
         @(posedge clk); #1;
         n++;
      end
      if (!acc) check("send_timeout", 0, 1);
   endtask

   task automatic wait_out();
      int n = 0;
      @(negedge clk);
      while (!out_valid && n < 100) begin @(negedge clk); n++; end
      if (!out_valid) check("out_valid_timeout", 0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin @(negedge clk); n++; end
      if (!in_ready) check("idle_timeout", 0, 1);
      @(posedge clk); #1;
   endtask

   initial begin
      int c, pc;
      #12;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_bcd_out", int'(bcd_out), 0);
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      check("rst_in_ready", int'(in_ready), 1);

      // single max value
      send(255, c);
      in_valid = 0;
      check("in_ready_drop", int'(in_ready), 0);
      check("busy_shift", int'(busy), 1);
      wait_out();
      check("bcd_255", int'(bcd_out), 'h255);
      @(posedge clk); #1;
      check("back_to_idle", int'({in_ready, out_valid}), 2);

      // exhaustive back-to-back sweep
      pc = -1;
      for (int v = 0; v < 256; v++) begin
         send(v, c);
         if (pc >= 0) check("accept_gap", c - pc, BIN_W + 2);
         pc = c;
      end
      in_valid = 0;
      wait_idle();

      // backpressure hold
      out_ready = 0;
      send(128, c);
      in_valid = 0;
      wait_out();
      for (int i = 0; i < 20; i++) begin
         check("hold", int'({out_valid, in_ready, bcd_out}), int'({1'b1, 1'b0, 12'h128}));
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1;
      @(posedge clk); #1;
      out_ready = 0;
      check("hold_release", int'({in_ready, out_valid}), 2);
      out_ready = 1;

      // random operands with random gaps and backpressure
      rand_on = 1;
      fork
         begin
            for (int i = 0; i < 40; i++) begin
               send($urandom_range(0, 255), c);
               in_valid = 0;
               repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            rand_on = 0;
         end
         begin
            while (rand_on) begin
               @(posedge clk); #1;
               out_ready = 1'($urandom_range(0, 1));
            end
            out_ready = 1;
         end
      join
      wait_idle();

      // operand offered during SHIFT is ignored
      send(37, c);
      bin_in = 8'd250;
      repeat (4) begin
         @(negedge clk);
         check("no_capture_busy", int'(in_ready), 0);
         @(posedge clk); #1;
      end
      in_valid = 0;
      wait_idle();
      check("bcd_037_held", int'(bcd_out), 'h037);

      // asynchronous reset mid-SHIFT
      send(173, c);
      in_valid = 0;
      repeat (4) @(posedge clk);
      #3;
      rst_n = 0;
      #1;
      check("async_rst", int'({in_ready, out_valid, busy, bcd_out}), int'({1'b1, 1'b0, 1'b0, 12'h000}));
      exp_q.delete();
      acc_q.delete();
      @(posedge clk); #1;
      check("rst_hold_bcd", int'(bcd_out), 0);
      rst_n = 1;
      @(posedge clk); #1;
      send(5, c);
      in_valid = 0;
      wait_out();
      check("bcd_005", int'(bcd_out), 'h005);
      wait_idle();
      check("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #2000000;
      check("global_timeout", 0, 1);
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "timeout");
   end

endmodule
